cu_decode_stage: RTL and testbench
==================================

Name: cu_decode_stage

Overview:
Registered RV32I/RV64I decode stage with a valid/ready handshake on both sides. It sits between the fetch and execute stages. It decodes one instruction per cycle into the existing control bundle and adds several things:
- parametrised XLEN, with RV64 *W ops
- optional M-extension decode
- full Zicsr operation encoding
- illegal-instruction detection
- a sticky ebreak halt, which replaces simulation-side state reporting

A 2-entry skid buffer keeps throughput at 1 instruction/cycle while in_ready stays registered.

Parameters:
XLEN, 32, datapath width; 32 or 64; 64 enables OP-32/OP-IMM-32 word ops and 6-bit shamt.
EN_M, 0, 1 = decode MUL/DIV/REM (plus *W when XLEN=64); 0 = those encodings are illegal.
EN_CSR, 1, 1 = decode Zicsr, ecall, mret; 0 = those are illegal.

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
flush  in  1  discard all buffered and incoming instructions
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage can accept (registered)
in_inst  in  32  instruction word
in_pc  in  XLEN  instruction PC
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  XLEN  PC of bundle
out_inst  out  32  raw instruction
rf_wr_en  out  1  register write enable
rf_wr_sel  out  2  00 csr/none, 01 pc+4, 10 alu, 11 mem
csr_op  out  3  000 none, 001 rw, 010 rs, 011 rc, 100 ecall, 101 mret
csr_imm  out  1  csr op uses zimm
do_jump  out  1  jal/jalr/ecall/mret
br_type  out  3  000 none, 010 beq, 011 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu
alu_a_sel  out  1  1 = rs1, 0 = pc
alu_b_sel  out  1  1 = imm, 0 = rs2
alu_ctrl  out  4  0000 add, 1000 sub, 0001 sll, 0101 srl, 1101 sra, 0010 slt, 0011 sltu, 0100 xor, 0110 or, 0111 and, 1110 passB, 1001 trap, 1010 csrrw, 1111 none
alu_word  out  1  RV64 32-bit op; result is sign-extended
md_op  out  4  bit3 = valid; [2:0] = funct3 of M op
dm_rd_ctrl  out  3  000 none, 001 lb, 010 lbu, 011 lh, 100 lhu, 101 lw, 110 lwu, 111 ld
dm_wr_ctrl  out  3  000 none, 001 sb, 010 sh, 011 sw, 100 sd
illegal  out  1  unrecognised encoding
halt  out  1  sticky; ebreak has retired from this stage

Behaviour:
- Reset (async on rst_n low):
  - state = EMPTY, halt = 0, in_ready = 1, out_valid = 0.
  - All bundle fields = 0, except alu_ctrl = 1111.
- Decode is purely combinational from in_inst. It is captured into the output register on accept, so latency is 1 cycle (in accept at edge N → out_valid at N+1).
- Skid states:
  - EMPTY: out_valid = 0.
  - ONE: output register full.
  - TWO: output register and skid register full.
- in_ready = (state != TWO) && !halt. It is a registered output.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready. Transitions:
  - EMPTY: accept → ONE.
  - ONE: accept && !drain → TWO; accept && drain → ONE (new bundle loaded); !accept && drain → EMPTY.
  - TWO: drain → ONE (skid moves into output register); no accept possible.
- Bundle outputs and out_pc/out_inst hold stable while out_valid && !out_ready.
- flush has priority over everything except reset. Next state = EMPTY, out_valid = 0, and any accept in the flush cycle is dropped. halt is unaffected.
- Illegal instruction:
  - Applies to any encoding not enabled by the parameters, and to funct7 mismatches on R-type/shifts.
  - RV32: slli/srli/srai with inst[25] = 1 is illegal.
  - Effect: illegal = 1; rf_wr_en, csr_op, dm_wr_ctrl, do_jump, br_type and md_op all 0; alu_ctrl = 1111.
- ebreak (0x00100073) is decoded legal with all enables 0. On its drain, halt is set; in_ready drops the next cycle and stays 0 until reset.
- M ops: rf_wr_en = 1, rf_wr_sel = 10, alu_ctrl = 1111, md_op = {1, funct3}.
- CSR ops: rf_wr_en = 1, rf_wr_sel = 10. ecall/mret: rf_wr_en = 0, do_jump = 1, alu_ctrl = 1001.
- Width rules:
  - lwu/ld/sd and all *W ops are illegal when XLEN = 32.
  - XLEN = 64: shamt is inst[25:20] for OP-IMM and inst[24:20] for OP-IMM-32.

Decomposition:
- Package cu_pkg holds the encoding constants for rf_wr_sel, csr_op, br_type, alu_ctrl, dm_rd_ctrl and dm_wr_ctrl, plus the opcode constants and a packed struct ctrl_bundle_t.
- Sub-module cu_decode_comb: combinational inst → ctrl_bundle_t, carrying the parameters.
- The top level holds only the skid FSM and the registers.

Test Plan:
1. Reset, then addi x1,x0,5 (0x00500093) with out_ready = 1 → next cycle out_valid = 1, rf_wr_en = 1, rf_wr_sel = 10, alu_ctrl = 0000, alu_b_sel = 1, illegal = 0.
2. Back-to-back add 0x002081B3, lw 0x00412283, sw 0x00112223 with out_ready held 0 → in_ready falls after 2 accepts. Then release → bundles arrive in order, with dm_rd_ctrl = 101 and dm_wr_ctrl = 011, and no loss or duplication.
3. mul 0x022081B3 with EN_M = 0 → illegal = 1, rf_wr_en = 0. With EN_M = 1 → md_op = 1000, illegal = 0.
4. XLEN = 64: addw 0x002081BB → alu_word = 1, alu_ctrl = 0000. Same word with XLEN = 32 → illegal = 1.
5. State TWO, assert flush for 1 cycle with in_valid = 1 → out_valid = 0 next cycle, in_ready = 1, the offered instruction never appears.
6. ebreak 0x00100073 drained → halt = 1, in_ready = 0 thereafter. Assert rst_n = 0 mid-stream → outputs return to reset values immediately (async).

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings and the decoded control bundle for the decode stage.
package cu_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_PC4  = 2'b01;
  localparam logic [1:0] WB_ALU  = 2'b10;
  localparam logic [1:0] WB_MEM  = 2'b11;

  localparam logic [2:0] CSR_NONE  = 3'b000;
  localparam logic [2:0] CSR_RW    = 3'b001;
  localparam logic [2:0] CSR_RS    = 3'b010;
  localparam logic [2:0] CSR_RC    = 3'b011;
  localparam logic [2:0] CSR_ECALL = 3'b100;
  localparam logic [2:0] CSR_MRET  = 3'b101;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b010;
  localparam logic [2:0] BR_BNE  = 3'b011;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;
  localparam logic [3:0] ALU_PASSB = 4'b1110;
  localparam logic [3:0] ALU_TRAP  = 4'b1001;
  localparam logic [3:0] ALU_CSRRW = 4'b1010;
  localparam logic [3:0] ALU_NONE  = 4'b1111;

  localparam logic [2:0] DMR_NONE = 3'b000;
  localparam logic [2:0] DMR_LB   = 3'b001;
  localparam logic [2:0] DMR_LBU  = 3'b010;
  localparam logic [2:0] DMR_LH   = 3'b011;
  localparam logic [2:0] DMR_LHU  = 3'b100;
  localparam logic [2:0] DMR_LW   = 3'b101;
  localparam logic [2:0] DMR_LWU  = 3'b110;
  localparam logic [2:0] DMR_LD   = 3'b111;

  localparam logic [2:0] DMW_NONE = 3'b000;
  localparam logic [2:0] DMW_SB   = 3'b001;
  localparam logic [2:0] DMW_SH   = 3'b010;
  localparam logic [2:0] DMW_SW   = 3'b011;
  localparam logic [2:0] DMW_SD   = 3'b100;

  typedef struct packed {
    logic       rf_wr_en;
    logic [1:0] rf_wr_sel;
    logic [2:0] csr_op;
    logic       csr_imm;
    logic       do_jump;
    logic [2:0] br_type;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [3:0] alu_ctrl;
    logic       alu_word;
    logic [3:0] md_op;
    logic [2:0] dm_rd_ctrl;
    logic [2:0] dm_wr_ctrl;
    logic       illegal;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_IDLE = '{
    rf_wr_en: 1'b0, rf_wr_sel: WB_NONE, csr_op: CSR_NONE, csr_imm: 1'b0,
    do_jump: 1'b0, br_type: BR_NONE, alu_a_sel: 1'b0, alu_b_sel: 1'b0,
    alu_ctrl: ALU_NONE, alu_word: 1'b0, md_op: 4'b0000,
    dm_rd_ctrl: DMR_NONE, dm_wr_ctrl: DMW_NONE, illegal: 1'b0};

  localparam ctrl_bundle_t CTRL_ILLEGAL = '{
    rf_wr_en: 1'b0, rf_wr_sel: WB_NONE, csr_op: CSR_NONE, csr_imm: 1'b0,
    do_jump: 1'b0, br_type: BR_NONE, alu_a_sel: 1'b0, alu_b_sel: 1'b0,
    alu_ctrl: ALU_NONE, alu_word: 1'b0, md_op: 4'b0000,
    dm_rd_ctrl: DMR_NONE, dm_wr_ctrl: DMW_NONE, illegal: 1'b1};

endpackage

// File: rtl/cu_decode_comb.sv
// Combinational RV32I/RV64I (+M, +Zicsr) instruction decoder producing ctrl_bundle_t.
module cu_decode_comb
  import cu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int EN_M   = 0,
  parameter int EN_CSR = 1
) (
  input  logic [31:0]  inst,
  output ctrl_bundle_t ctrl
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ill;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  always_comb begin
    ctrl = CTRL_IDLE;
    ill  = 1'b0;
    case (opc)
      OPC_LUI: begin
        ctrl.rf_wr_en  = 1'b1;
        ctrl.rf_wr_sel = WB_ALU;
        ctrl.alu_b_sel = 1'b1;
        ctrl.alu_ctrl  = ALU_PASSB;
      end
      OPC_AUIPC: begin
        ctrl.rf_wr_en  = 1'b1;
        ctrl.rf_wr_sel = WB_ALU;
        ctrl.alu_b_sel = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      OPC_JAL: begin
        ctrl.rf_wr_en  = 1'b1;
        ctrl.rf_wr_sel = WB_PC4;
        ctrl.do_jump   = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      OPC_JALR: begin
        ill            = (f3 != 3'b000);
        ctrl.rf_wr_en  = 1'b1;
        ctrl.rf_wr_sel = WB_PC4;
        ctrl.do_jump   = 1'b1;
        ctrl.alu_a_sel = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      OPC_BRANCH: begin
        // funct3 010/011 are holes; the rest map onto br_type with a small remap of beq/bne
        ill            = (f3[2:1] == 2'b01);
        ctrl.br_type   = f3[2] ? f3 : {2'b01, f3[0]};
        ctrl.alu_b_sel = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
      end
      OPC_LOAD: begin
        ctrl.rf_wr_en  = 1'b1;
        ctrl.rf_wr_sel = WB_MEM;
        ctrl.alu_a_sel = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
        case (f3)
          3'b000:  ctrl.dm_rd_ctrl = DMR_LB;
          3'b001:  ctrl.dm_rd_ctrl = DMR_LH;
          3'b010:  ctrl.dm_rd_ctrl = DMR_LW;
          3'b011:  begin ctrl.dm_rd_ctrl = DMR_LD;  ill = !RV64; end
          3'b100:  ctrl.dm_rd_ctrl = DMR_LBU;
          3'b101:  ctrl.dm_rd_ctrl = DMR_LHU;
          3'b110:  begin ctrl.dm_rd_ctrl = DMR_LWU; ill = !RV64; end
          default: ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctrl.alu_a_sel = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.alu_ctrl  = ALU_ADD;
        case (f3)
          3'b000:  ctrl.dm_wr_ctrl = DMW_SB;
          3'b001:  ctrl.dm_wr_ctrl = DMW_SH;
          3'b010:  ctrl.dm_wr_ctrl = DMW_SW;
          3'b011:  begin ctrl.dm_wr_ctrl = DMW_SD; ill = !RV64; end
          default: ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        ctrl.rf_wr_en  = 1'b1;
        ctrl.rf_wr_sel = WB_ALU;
        ctrl.alu_a_sel = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.alu_ctrl  = {1'b0, f3};
        // RV64 shamt borrows inst[25], so only inst[31:26] is checked there
        if (f3 == 3'b001) begin
          ill = RV64 ? (inst[31:26] != 6'b000000) : (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          ctrl.alu_ctrl = {inst[30], f3};
          ill = RV64 ? !(inst[31:26] == 6'b000000 || inst[31:26] == 6'b010000)
                     : !(f7 == 7'b0000000 || f7 == 7'b0100000);
        end
      end
      OPC_OP_IMM_32: begin
        ctrl.rf_wr_en  = 1'b1;
        ctrl.rf_wr_sel = WB_ALU;
        ctrl.alu_a_sel = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.alu_word  = 1'b1;
        case (f3)
          3'b000:  ctrl.alu_ctrl = ALU_ADD;
          3'b001:  begin ctrl.alu_ctrl = ALU_SLL; ill = (f7 != 7'b0000000); end
          3'b101: begin
            ctrl.alu_ctrl = {inst[30], f3};
            ill = !(f7 == 7'b0000000 || f7 == 7'b0100000);
          end
          default: ill = 1'b1;
        endcase
        if (!RV64) ill = 1'b1;
      end
      OPC_OP: begin
        ctrl.rf_wr_en  = 1'b1;
        ctrl.rf_wr_sel = WB_ALU;
        ctrl.alu_a_sel = 1'b1;
        if (f7 == 7'b0000001) begin
          ctrl.md_op = {1'b1, f3};
          ill        = (EN_M == 0);
        end else if (f7 == 7'b0000000) begin
          ctrl.alu_ctrl = {1'b0, f3};
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          ctrl.alu_ctrl = {1'b1, f3};
        end else begin
          ill = 1'b1;
        end
      end
      OPC_OP_32: begin
        ctrl.rf_wr_en  = 1'b1;
        ctrl.rf_wr_sel = WB_ALU;
        ctrl.alu_a_sel = 1'b1;
        ctrl.alu_word  = 1'b1;
        if (f7 == 7'b0000001) begin
          ctrl.md_op = {1'b1, f3};
          ill = (EN_M == 0) || (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011);
        end else if ((f7 == 7'b0000000 || f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101)) begin
          ctrl.alu_ctrl = {f7[5], f3};
        end else if (f7 == 7'b0000000 && f3 == 3'b001) begin
          ctrl.alu_ctrl = ALU_SLL;
        end else begin
          ill = 1'b1;
        end
        if (!RV64) ill = 1'b1;
      end
      OPC_MISC_MEM: begin
        ill = (f3 != 3'b000);
      end
      OPC_SYSTEM: begin
        if (f3 == 3'b000) begin
          if (inst == INST_ECALL || inst == INST_MRET) begin
            ctrl.csr_op   = (inst == INST_ECALL) ? CSR_ECALL : CSR_MRET;
            ctrl.do_jump  = 1'b1;
            ctrl.alu_ctrl = ALU_TRAP;
          end else if (inst != INST_EBREAK) begin
            ill = 1'b1;
          end
        end else if (f3 == 3'b100) begin
          ill = 1'b1;
        end else begin
          ctrl.rf_wr_en  = 1'b1;
          ctrl.rf_wr_sel = WB_ALU;
          ctrl.alu_a_sel = 1'b1;
          ctrl.alu_ctrl  = ALU_CSRRW;
          ctrl.csr_op    = {1'b0, f3[1:0]};
          ctrl.csr_imm   = f3[2];
        end
        if (EN_CSR == 0 && inst != INST_EBREAK) ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ill) ctrl = CTRL_ILLEGAL;
  end

endmodule

// File: rtl/cu_decode_stage.sv
// Registered decode stage: 1-cycle latency, 2-entry skid so in_ready is a flop yet
// throughput stays at one instruction per cycle; sticky halt once an ebreak drains.
module cu_decode_stage
  import cu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int EN_M   = 0,
  parameter int EN_CSR = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic            rf_wr_en,
  output logic [1:0]      rf_wr_sel,
  output logic [2:0]      csr_op,
  output logic            csr_imm,
  output logic            do_jump,
  output logic [2:0]      br_type,
  output logic            alu_a_sel,
  output logic            alu_b_sel,
  output logic [3:0]      alu_ctrl,
  output logic            alu_word,
  output logic [3:0]      md_op,
  output logic [2:0]      dm_rd_ctrl,
  output logic [2:0]      dm_wr_ctrl,
  output logic            illegal,
  output logic            halt
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t          state, state_nxt;
  ctrl_bundle_t    dec, out_q, skid_q;
  logic [XLEN-1:0] skid_pc;
  logic [31:0]     skid_inst;
  logic            accept, drain, halt_nxt;

  cu_decode_comb #(.XLEN(XLEN), .EN_M(EN_M), .EN_CSR(EN_CSR)) u_dec (
    .inst (in_inst),
    .ctrl (dec)
  );

  always_comb begin
    accept    = in_valid && in_ready;
    drain     = out_valid && out_ready;
    state_nxt = state;
    case (state)
      S_EMPTY: if (accept) state_nxt = S_ONE;
      S_ONE: begin
        if (accept && !drain)      state_nxt = S_TWO;
        else if (!accept && drain) state_nxt = S_EMPTY;
      end
      S_TWO:   if (drain) state_nxt = S_ONE;
      default: state_nxt = S_EMPTY;
    endcase
    if (flush) state_nxt = S_EMPTY;
    halt_nxt = halt || (drain && !flush && out_inst == INST_EBREAK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      halt      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_q     <= CTRL_IDLE;
      out_pc    <= '0;
      out_inst  <= '0;
      skid_q    <= CTRL_IDLE;
      skid_pc   <= '0;
      skid_inst <= '0;
    end else begin
      state     <= state_nxt;
      halt      <= halt_nxt;
      in_ready  <= (state_nxt != S_TWO) && !halt_nxt;
      out_valid <= (state_nxt != S_EMPTY);
      if (!flush) begin
        case (state)
          S_EMPTY: if (accept) begin
            out_q    <= dec;
            out_pc   <= in_pc;
            out_inst <= in_inst;
          end
          S_ONE: begin
            if (accept && drain) begin
              out_q    <= dec;
              out_pc   <= in_pc;
              out_inst <= in_inst;
            end else if (accept) begin
              skid_q    <= dec;
              skid_pc   <= in_pc;
              skid_inst <= in_inst;
            end
          end
          S_TWO: if (drain) begin
            out_q    <= skid_q;
            out_pc   <= skid_pc;
            out_inst <= skid_inst;
          end
          default: ;
        endcase
      end
    end
  end

  assign rf_wr_en   = out_q.rf_wr_en;
  assign rf_wr_sel  = out_q.rf_wr_sel;
  assign csr_op     = out_q.csr_op;
  assign csr_imm    = out_q.csr_imm;
  assign do_jump    = out_q.do_jump;
  assign br_type    = out_q.br_type;
  assign alu_a_sel  = out_q.alu_a_sel;
  assign alu_b_sel  = out_q.alu_b_sel;
  assign alu_ctrl   = out_q.alu_ctrl;
  assign alu_word   = out_q.alu_word;
  assign md_op      = out_q.md_op;
  assign dm_rd_ctrl = out_q.dm_rd_ctrl;
  assign dm_wr_ctrl = out_q.dm_wr_ctrl;
  assign illegal    = out_q.illegal;

endmodule

// File: tb/tb_cu_decode_stage.sv
// Bench for cu_decode_stage: an RV32 (no M) and an RV64 (+M) instance share one input stream.
module tb_cu_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready, out_valid, rf_wr_en, csr_imm, do_jump, alu_a_sel, alu_b_sel, alu_word, illegal, halt;
  logic [31:0] out_pc, out_inst;
  logic [1:0]  rf_wr_sel;
  logic [2:0]  csr_op, br_type, dm_rd_ctrl, dm_wr_ctrl;
  logic [3:0]  alu_ctrl, md_op;

  logic        in_ready_w, out_valid_w, rf_wr_en_w, csr_imm_w, do_jump_w, alu_a_sel_w, alu_b_sel_w, alu_word_w, illegal_w, halt_w;
  logic [63:0] out_pc_w;
  logic [31:0] out_inst_w;
  logic [1:0]  rf_wr_sel_w;
  logic [2:0]  csr_op_w, br_type_w, dm_rd_ctrl_w, dm_wr_ctrl_w;
  logic [3:0]  alu_ctrl_w, md_op_w;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        wr_en;
    logic [1:0]  sel;
    logic [2:0]  rd;
    logic [2:0]  wr;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cu_decode_stage #(.XLEN(32), .EN_M(0), .EN_CSR(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel),
    .csr_op(csr_op), .csr_imm(csr_imm), .do_jump(do_jump), .br_type(br_type),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_ctrl(alu_ctrl), .alu_word(alu_word),
    .md_op(md_op), .dm_rd_ctrl(dm_rd_ctrl), .dm_wr_ctrl(dm_wr_ctrl), .illegal(illegal), .halt(halt)
  );

  cu_decode_stage #(.XLEN(64), .EN_M(1), .EN_CSR(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_inst(in_inst), .in_pc({32'd0, in_pc}), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_pc(out_pc_w), .out_inst(out_inst_w), .rf_wr_en(rf_wr_en_w), .rf_wr_sel(rf_wr_sel_w),
    .csr_op(csr_op_w), .csr_imm(csr_imm_w), .do_jump(do_jump_w), .br_type(br_type_w),
    .alu_a_sel(alu_a_sel_w), .alu_b_sel(alu_b_sel_w), .alu_ctrl(alu_ctrl_w), .alu_word(alu_word_w),
    .md_op(md_op_w), .dm_rd_ctrl(dm_rd_ctrl_w), .dm_wr_ctrl(dm_wr_ctrl_w), .illegal(illegal_w), .halt(halt_w)
  );

  // Offer one instruction with out_ready high; returns when its bundle is on the outputs.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (alu_ctrl !== 4'b1111) begin errors++; $display("FAIL reset_alu_ctrl got=%b want=1111", alu_ctrl); end
    checks++; if (rf_wr_en !== 1'b0 || dm_wr_ctrl !== 3'b000 || md_op !== 4'b0000) begin errors++; $display("FAIL reset_bundle got=%b/%b/%b want=0", rf_wr_en, dm_wr_ctrl, md_op); end
    checks++; if (halt !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL reset_halt_illegal got=%b/%b want=0/0", halt, illegal); end
    checks++; if (in_ready_w !== 1'b1 || out_valid_w !== 1'b0) begin errors++; $display("FAIL reset_wide got=%b/%b want=1/0", in_ready_w, out_valid_w); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addi;
    send(32'h0050_0093, 32'h100);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_latency got=%b want=1", out_valid); end
    checks++; if (rf_wr_en !== 1'b1 || rf_wr_sel !== 2'b10) begin errors++; $display("FAIL addi_wb got=%b/%b want=1/10", rf_wr_en, rf_wr_sel); end
    checks++; if (alu_ctrl !== 4'b0000 || alu_b_sel !== 1'b1 || alu_a_sel !== 1'b1) begin errors++; $display("FAIL addi_alu got=%b/%b/%b want=0000/1/1", alu_ctrl, alu_b_sel, alu_a_sel); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL addi_illegal got=%b want=0", illegal); end
    checks++; if (out_pc !== 32'h100 || out_inst !== 32'h0050_0093) begin errors++; $display("FAIL addi_pc_inst got=%h/%h want=100/00500093", out_pc, out_inst); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] tbl [3];
    logic        wen [3];
    logic [1:0]  sel [3];
    logic [2:0]  rd  [3];
    logic [2:0]  wr  [3];
    int          sent, got;
    exp_t        e;
    tbl[0] = 32'h0020_81B3; wen[0] = 1'b1; sel[0] = 2'b10; rd[0] = 3'b000; wr[0] = 3'b000;
    tbl[1] = 32'h0041_2283; wen[1] = 1'b1; sel[1] = 2'b11; rd[1] = 3'b101; wr[1] = 3'b000;
    tbl[2] = 32'h0011_2223; wen[2] = 1'b0; sel[2] = 2'b00; rd[2] = 3'b000; wr[2] = 3'b011;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 30 && got < 3; cyc++) begin
      @(negedge clk);
      if (cyc == 3) begin
        checks++; if (in_ready !== 1'b0 || sent != 2) begin errors++; $display("FAIL b2b_stall in_ready=%b sent=%0d want 0 after 2", in_ready, sent); end
      end
      in_valid  = (sent < 3);
      in_inst   = (sent < 3) ? tbl[sent] : 32'h0;
      in_pc     = 32'h200 + 32'(sent * 4);
      out_ready = (cyc >= 5);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got inst=%h want nothing", out_inst);
        end else begin
          e = exp_q.pop_front();
          if (out_inst !== e.inst || out_pc !== e.pc || rf_wr_en !== e.wr_en || rf_wr_sel !== e.sel ||
              dm_rd_ctrl !== e.rd || dm_wr_ctrl !== e.wr) begin
            errors++;
            $display("FAIL b2b_bundle got inst=%h pc=%h wen=%b sel=%b rd=%b wr=%b want inst=%h pc=%h wen=%b sel=%b rd=%b wr=%b",
                     out_inst, out_pc, rf_wr_en, rf_wr_sel, dm_rd_ctrl, dm_wr_ctrl, e.inst, e.pc, e.wr_en, e.sel, e.rd, e.wr);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        e.inst = tbl[sent]; e.pc = in_pc; e.wr_en = wen[sent]; e.sel = sel[sent]; e.rd = rd[sent]; e.wr = wr[sent];
        exp_q.push_back(e);
        sent++;
      end
    end
    in_valid = 1'b0;
    checks++; if (got != 3 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_count got=%0d pending=%0d want 3/0", got, exp_q.size()); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_mul_ext;
    send(32'h0220_81B3, 32'h300);
    checks++; if (illegal !== 1'b1 || rf_wr_en !== 1'b0 || md_op !== 4'b0000 || alu_ctrl !== 4'b1111) begin errors++; $display("FAIL mul_nom got ill=%b wen=%b md=%b alu=%b want 1/0/0000/1111", illegal, rf_wr_en, md_op, alu_ctrl); end
    checks++; if (md_op_w !== 4'b1000 || illegal_w !== 1'b0) begin errors++; $display("FAIL mul_m got md=%b ill=%b want 1000/0", md_op_w, illegal_w); end
    checks++; if (rf_wr_en_w !== 1'b1 || rf_wr_sel_w !== 2'b10 || alu_ctrl_w !== 4'b1111) begin errors++; $display("FAIL mul_m_wb got wen=%b sel=%b alu=%b want 1/10/1111", rf_wr_en_w, rf_wr_sel_w, alu_ctrl_w); end
  endtask

  task automatic test_word;
    send(32'h0020_81BB, 32'h310);
    checks++; if (alu_word_w !== 1'b1 || alu_ctrl_w !== 4'b0000 || illegal_w !== 1'b0) begin errors++; $display("FAIL addw_64 got word=%b alu=%b ill=%b want 1/0000/0", alu_word_w, alu_ctrl_w, illegal_w); end
    checks++; if (illegal !== 1'b1 || alu_word !== 1'b0 || rf_wr_en !== 1'b0) begin errors++; $display("FAIL addw_32 got ill=%b word=%b wen=%b want 1/0/0", illegal, alu_word, rf_wr_en); end
    send(32'h0200_9093, 32'h314);
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL slli32_rv32 got ill=%b want 1", illegal); end
    checks++; if (illegal_w !== 1'b0 || alu_ctrl_w !== 4'b0001) begin errors++; $display("FAIL slli32_rv64 got ill=%b alu=%b want 0/0001", illegal_w, alu_ctrl_w); end
  endtask

  task automatic test_system;
    send(32'h0000_0073, 32'h320);
    checks++; if (csr_op !== 3'b100 || do_jump !== 1'b1 || rf_wr_en !== 1'b0 || alu_ctrl !== 4'b1001) begin errors++; $display("FAIL ecall got csr=%b jmp=%b wen=%b alu=%b want 100/1/0/1001", csr_op, do_jump, rf_wr_en, alu_ctrl); end
    send(32'h3000_1073, 32'h324);
    checks++; if (csr_op !== 3'b001 || rf_wr_en !== 1'b1 || rf_wr_sel !== 2'b10 || alu_ctrl !== 4'b1010) begin errors++; $display("FAIL csrrw got csr=%b wen=%b sel=%b alu=%b want 001/1/10/1010", csr_op, rf_wr_en, rf_wr_sel, alu_ctrl); end
    send(32'h0020_8463, 32'h328);
    checks++; if (br_type !== 3'b010 || rf_wr_en !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL beq got br=%b wen=%b ill=%b want 010/0/0", br_type, rf_wr_en, illegal); end
  endtask

  task automatic test_flush;
    exp_t e;
    @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h400;
    @(negedge clk); in_inst = 32'h0020_81B3; in_pc = 32'h404;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_two got rdy=%b vld=%b want 0/1", in_ready, out_valid); end
    flush = 1'b1; in_inst = 32'h0070_0113; in_pc = 32'h408;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_empty got vld=%b rdy=%b want 0/1", out_valid, in_ready); end
    in_inst = 32'h0090_0193; in_pc = 32'h40C;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got vld=%b want 0", out_valid); end
    flush = 1'b0; in_inst = 32'h00B0_0213; in_pc = 32'h410; out_ready = 1'b1;
    if (in_valid && in_ready) begin
      e.inst = in_inst; e.pc = in_pc; e.wr_en = 1'b1; e.sel = 2'b10; e.rd = 3'b000; e.wr = 3'b000;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (exp_q.size() == 0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_resume got vld=%b pending=%0d want 1/1", out_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (out_inst !== e.inst || out_pc !== e.pc || rf_wr_en !== e.wr_en) begin errors++; $display("FAIL flush_resume got inst=%h pc=%h want inst=%h pc=%h", out_inst, out_pc, e.inst, e.pc); end
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after got vld=%b want 0", out_valid); end
  endtask

  task automatic test_ebreak_reset;
    send(32'h0010_0073, 32'h500);
    checks++; if (out_valid !== 1'b1 || illegal !== 1'b0 || rf_wr_en !== 1'b0 || do_jump !== 1'b0 || halt !== 1'b0) begin errors++; $display("FAIL ebreak_bundle got vld=%b ill=%b wen=%b jmp=%b halt=%b want 1/0/0/0/0", out_valid, illegal, rf_wr_en, do_jump, halt); end
    @(negedge clk);
    checks++; if (halt !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL ebreak_halt got halt=%b rdy=%b want 1/0", halt, in_ready); end
    in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h504;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || halt !== 1'b1) begin errors++; $display("FAIL halt_sticky got rdy=%b vld=%b halt=%b want 0/0/1", in_ready, out_valid, halt); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (halt !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL async_reset got halt=%b rdy=%b vld=%b want 0/1/0", halt, in_ready, out_valid); end
    checks++; if (halt_w !== 1'b0 || alu_ctrl !== 4'b1111 || illegal !== 1'b0) begin errors++; $display("FAIL async_reset_bundle got halt_w=%b alu=%b ill=%b want 0/1111/0", halt_w, alu_ctrl, illegal); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_mul_ext();
    test_word();
    test_system();
    test_flush();
    test_ebreak_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
